clk_div_prog: RTL

Programmable integer clock divider, successor to the team's fixed divide-by-7 block.
- Divides `clk` by a runtime-loadable ratio N (2..2^CNT_W-1).
- Provides a divided level output, a one-cycle period-start strobe, and glitch-free ratio changes at period boundaries.
- Used as the common tick/clock-enable source for display scan, debounce and LED blink logic.

---
 rtl/clk_div_prog.sv | 106 ++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// +----------------------------------------------------------------------------+
// | clk_div_prog : programmable integer clock divider with period-start tick   |
// | Optional macro CLK_DIV_ODD50_EN: exact 50% duty for odd ratios (negedge).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] c_div_min = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_def_div =
      (DEFAULT_DIV < 2) ? c_div_min : CNT_W'(DEFAULT_DIV);

  function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] v);
    return (v < c_div_min) ? c_div_min : v;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_v;
  logic             r_pos;
  logic             r_tick;

  logic             w_wrap;
  logic [CNT_W-1:0] w_ld_div;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_div_next;
  logic [CNT_W-1:0] w_half_next;

  assign w_wrap   = en & (r_cnt == (r_cur_div - CNT_W'(1)));
  assign w_ld_div = f_clamp(div_val);

  // A load on the wrap edge beats any older pending ratio.
  always_comb begin
    w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_div_next = r_cur_div;
    if (w_wrap) begin
      if (load) begin
        w_div_next = w_ld_div;
      end else if (r_pend_v) begin
        w_div_next = r_pend_div;
      end
    end
    w_half_next = w_div_next >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= c_def_div - CNT_W'(1);
      r_cur_div  <= c_def_div;
      r_pend_div <= '0;
      r_pend_v   <= 1'b0;
      r_pos      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick    <= w_wrap;
      r_cur_div <= w_div_next;
      if (en) begin
        r_cnt <= w_cnt_next;
        r_pos <= (w_cnt_next < w_half_next);
      end
      if (w_wrap) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_div <= w_ld_div;
        r_pend_v   <= 1'b1;
      end
    end
  end

  assign tick    = r_tick;
  assign pending = r_pend_v;

`ifdef CLK_DIV_ODD50_EN
  logic r_neg;

  // Half-cycle delayed copy stretches the high phase by 0.5 clk for odd N.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign clk_out = r_cur_div[0] ? (r_pos | r_neg) : r_pos;
`else
  assign clk_out = r_pos;
`endif

endmodule

`default_nettype wire
